// File: rtl/led_mode_ctrl_if.sv
// Pin-side bundle of the LED mode controller: raw key in, LED drive and status out.
// The controller takes the slave view; whatever drives the key takes the master view.
interface led_mode_ctrl_if;
    logic       key;
    logic       led;
    logic [2:0] mode;
    logic       press_pulse;

    modport master (output key, input led, mode, press_pulse);
    modport slave  (input key, output led, mode, press_pulse);
endinterface

// File: rtl/led_mode_ctrl.sv
// Push-button LED sequencer: the key is synchronised and debounced, and each press steps
// the LED through OFF, ON, slow blink, fast blink and PWM breathing.
module led_mode_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int SLOW_HALF  = 25000000,
    parameter int FAST_HALF  = 5000000,
    parameter int PWM_PERIOD = 1000,
    parameter int BREATH_DIV = 25
) (
    input logic            sys_clk,
    input logic            sys_rst,
    led_mode_ctrl_if.slave io
);
    localparam int DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int BLINK_W   = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;
    localparam int PWM_W     = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int DUTY_W    = $clog2(PWM_PERIOD + 1);
    localparam int DIV_W     = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;

    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF - 1);
    localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF - 1);
    localparam logic [PWM_W-1:0]   PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(BREATH_DIV - 1);
    localparam logic [DUTY_W-1:0]  DUTY_MAX  = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0]  DUTY_ONE  = DUTY_W'(1);

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_ON     = 3'd1,
        MODE_SLOW   = 3'd2,
        MODE_FAST   = 3'd3,
        MODE_BREATH = 3'd4
    } mode_t;

    logic             sync1_reg, sync2_reg;
    logic             stable_reg, stable_d_reg;
    logic             press_reg;
    logic [DEB_W-1:0] deb_cnt_reg;

    // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            stable_reg   <= 1'b1;
            stable_d_reg <= 1'b1;
            deb_cnt_reg  <= '0;
            press_reg    <= 1'b0;
        end else begin
            sync1_reg    <= io.key;
            sync2_reg    <= sync1_reg;
            stable_d_reg <= stable_reg;
            press_reg    <= stable_d_reg & ~stable_reg;
            if (sync2_reg == stable_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                stable_reg  <= sync2_reg;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    mode_t              mode_reg, mode_next;
    logic               mode_legal;
    logic               led_reg, level_reg, dir_down_reg;
    logic [BLINK_W-1:0] blink_cnt_reg, blink_last;
    logic [PWM_W-1:0]   pwm_cnt_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [DUTY_W-1:0]  duty_reg;

    always_comb begin
        mode_next  = MODE_OFF;
        mode_legal = 1'b1;
        case (mode_reg)
            MODE_OFF:    mode_next = MODE_ON;
            MODE_ON:     mode_next = MODE_SLOW;
            MODE_SLOW:   mode_next = MODE_FAST;
            MODE_FAST:   mode_next = MODE_BREATH;
            MODE_BREATH: mode_next = MODE_OFF;
            default:     mode_legal = 1'b0;
        endcase
        blink_last = (mode_reg == MODE_FAST) ? FAST_LAST : SLOW_LAST;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_reg      <= MODE_OFF;
            led_reg       <= 1'b0;
            level_reg     <= 1'b1;
            dir_down_reg  <= 1'b0;
            blink_cnt_reg <= '0;
            pwm_cnt_reg   <= '0;
            div_cnt_reg   <= '0;
            duty_reg      <= '0;
        end else begin
            case (mode_reg)
                MODE_ON:              led_reg <= 1'b1;
                MODE_SLOW, MODE_FAST: led_reg <= level_reg;
                MODE_BREATH:          led_reg <= (DUTY_W'(pwm_cnt_reg) < duty_reg);
                default:              led_reg <= 1'b0;
            endcase

            // A mode change takes priority over any blink or duty step on the same edge.
            if (press_reg || !mode_legal) begin
                mode_reg      <= mode_next;
                level_reg     <= 1'b1;
                dir_down_reg  <= 1'b0;
                blink_cnt_reg <= '0;
                pwm_cnt_reg   <= '0;
                div_cnt_reg   <= '0;
                duty_reg      <= '0;
            end else if (mode_reg == MODE_SLOW || mode_reg == MODE_FAST) begin
                if (blink_cnt_reg == blink_last) begin
                    blink_cnt_reg <= '0;
                    level_reg     <= ~level_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end else if (mode_reg == MODE_BREATH) begin
                if (pwm_cnt_reg == PWM_LAST) begin
                    pwm_cnt_reg <= '0;
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= '0;
                        if (dir_down_reg) begin
                            duty_reg <= duty_reg - DUTY_ONE;
                            if (duty_reg == DUTY_ONE) dir_down_reg <= 1'b0;
                        end else begin
                            duty_reg <= duty_reg + DUTY_ONE;
                            if (duty_reg == DUTY_MAX - DUTY_ONE) dir_down_reg <= 1'b1;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end else begin
                    pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign io.led         = led_reg;
    assign io.mode        = mode_reg;
    assign io.press_pulse = press_reg;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with short timing parameters: vector table, directed corner
// sequences and random key activity, all checked against a timing-level reference.
module tb_led_mode_ctrl;
    localparam int DEB  = 4;
    localparam int SLOW = 8;
    localparam int FAST = 3;
    localparam int P    = 4;
    localparam int DIV  = 1;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    led_mode_ctrl_if io();

    led_mode_ctrl #(
        .DEB_CYCLES(DEB), .SLOW_HALF(SLOW), .FAST_HALF(FAST),
        .PWM_PERIOD(P), .BREATH_DIV(DIV)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .io     (io.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: key seen two edges late, a level is accepted once the last DEB seen
    // samples all disagree with it; LED follows from mode and edges since mode entry.
    bit ks_q[$];
    bit win[$];
    bit m_stable, m_fell, m_press, m_led;
    int m_mode, m_age;

    function automatic int duty_tri(int steps);
        int s;
        s = steps % (2 * P);
        return (s <= P) ? s : 2 * P - s;
    endfunction

    function automatic bit led_ref(int mode, int age);
        case (mode)
            1:       return 1'b1;
            2:       return ((age / SLOW) % 2) == 0;
            3:       return ((age / FAST) % 2) == 0;
            4:       return (age % P) < duty_tri((age / P) / DIV);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        ks_q.delete();
        ks_q.push_back(1'b1);
        ks_q.push_back(1'b1);
        win.delete();
        m_stable = 1'b1;
        m_fell   = 1'b0;
        m_press  = 1'b0;
        m_led    = 1'b0;
        m_mode   = 0;
        m_age    = 0;
    endtask

    task automatic model_step(input bit k, input bit r);
        bit ks;
        bit all_opp;
        if (r) begin
            model_reset();
            return;
        end
        m_led = led_ref(m_mode, m_age);
        if (m_press) begin
            m_mode = (m_mode + 1) % 5;
            m_age  = 0;
        end else begin
            m_age++;
        end
        m_press = m_fell;
        ks = ks_q.pop_front();
        ks_q.push_back(k);
        win.push_back(ks);
        if (win.size() > DEB) void'(win.pop_front());
        all_opp = (win.size() == DEB);
        foreach (win[i]) if (win[i] == m_stable) all_opp = 1'b0;
        m_fell = 1'b0;
        if (all_opp) begin
            m_stable = ~m_stable;
            m_fell   = ~m_stable;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, step the reference on the edge, compare on the falling edge.
    task automatic cyc(input bit k, input bit r);
        io.key  = k;
        sys_rst = r;
        @(posedge sys_clk);
        model_step(k, r);
        @(negedge sys_clk);
        checks++;
        if (io.led !== m_led || io.mode !== 3'(m_mode) || io.press_pulse !== m_press) begin
            failures++;
            $display("FAIL model t=%0t got led=%0b mode=%0d press=%0b expected led=%0b mode=%0d press=%0b",
                     $time, io.led, io.mode, io.press_pulse, m_led, m_mode, m_press);
        end
    endtask

    task automatic press_once();
        int  start;
        bit  changed;
        start   = int'(io.mode);
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0);
            if (int'(io.mode) != start) begin
                changed = 1'b1;
                break;
            end
        end
        chk("press_mode_change", int'(changed), 1);
    endtask

    task automatic goto_mode(input int t);
        for (int n = 0; n < 6 && int'(io.mode) != t; n++) begin
            repeat (8) cyc(1'b1, 1'b0);
            press_once();
        end
        chk($sformatf("goto_mode%0d", t), int'(io.mode), t);
    endtask

    task automatic measure_blink(input string tag, input int half, input int n);
        bit s[64];
        int runs[3];
        int ri;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            s[i] = io.led;
        end
        runs[0] = 1; runs[1] = 0; runs[2] = 0;
        ri = 0;
        for (int i = 1; i < n; i++) begin
            if (s[i] != s[i-1]) begin
                ri++;
                if (ri < 3) runs[ri] = 1;
            end else if (ri < 3) begin
                runs[ri]++;
            end
        end
        chk({tag, "_first_level"}, int'(s[0]), 1);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_run%0d", tag, i), runs[i], half);
    endtask

    typedef struct {
        bit rst;
        bit key;
        int cycles;
        int pulses;
        int mode;
        int led;    // -1: not checked
    } vec_t;

    vec_t tbl[16];
    int   bexp[10];
    int   np, first, h, ones, bad_mode;
    bit   mode_s[13][3];
    int   mode_v[13];
    bit   led_v[13];
    bit   press_v[13];
    int   cyc_total, len;
    bit   kr;

    initial begin
        tbl[0]  = '{1'b1, 1'b1,   3, 0, 0,  0};
        tbl[1]  = '{1'b0, 1'b1,  10, 0, 0,  0};
        tbl[2]  = '{1'b0, 1'b0,   3, 0, 0,  0};
        tbl[3]  = '{1'b0, 1'b1,  10, 0, 0,  0};
        tbl[4]  = '{1'b0, 1'b0,   1, 0, 0,  0};
        tbl[5]  = '{1'b0, 1'b1,  10, 0, 0,  0};
        tbl[6]  = '{1'b0, 1'b0, 100, 1, 1,  1};
        tbl[7]  = '{1'b0, 1'b1,  12, 0, 1,  1};
        tbl[8]  = '{1'b0, 1'b0,  12, 1, 2, -1};
        tbl[9]  = '{1'b0, 1'b1,  12, 0, 2, -1};
        tbl[10] = '{1'b0, 1'b0,  12, 1, 3, -1};
        tbl[11] = '{1'b0, 1'b1,  12, 0, 3, -1};
        tbl[12] = '{1'b0, 1'b0,  12, 1, 4, -1};
        tbl[13] = '{1'b0, 1'b1,  12, 0, 4, -1};
        tbl[14] = '{1'b0, 1'b0,  12, 1, 0,  0};
        tbl[15] = '{1'b0, 1'b1,  12, 0, 0,  0};
        bexp = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

        io.key  = 1'b1;
        sys_rst = 1'b1;
        model_reset();

        for (int i = 0; i < 16; i++) begin
            np = 0;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                cyc(tbl[i].key, tbl[i].rst);
                np += int'(io.press_pulse);
            end
            chk($sformatf("vec%0d_pulses", i), np, tbl[i].pulses);
            chk($sformatf("vec%0d_mode", i), int'(io.mode), tbl[i].mode);
            if (tbl[i].led >= 0) chk($sformatf("vec%0d_led", i), int'(io.led), tbl[i].led);
        end

        // Press latency and single pulse on a long hold
        np = 0;
        first = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc(1'b0, 1'b0);
            if (io.press_pulse) begin
                np++;
                if (first == 0) first = k;
            end
            if (k == 7) chk("hold_mode_at_pulse", int'(io.mode), 0);
            if (k == 8) begin
                chk("hold_mode_step", int'(io.mode), 1);
                chk("hold_led_lag", int'(io.led), 0);
            end
            if (k == 9) chk("hold_led_on", int'(io.led), 1);
        end
        chk("hold_pulse_cycle", first, 7);
        chk("hold_pulse_count", np, 1);
        repeat (10) cyc(1'b1, 1'b0);

        goto_mode(2);
        measure_blink("slow", SLOW, 30);
        goto_mode(3);
        measure_blink("fast", FAST, 12);

        goto_mode(4);
        for (int g = 0; g < 10; g++) begin
            h = 0;
            repeat (P) begin
                cyc(1'b1, 1'b0);
                h += int'(io.led);
            end
            chk($sformatf("breath_period%0d", g), h, bexp[g]);
        end

        // Press landing exactly on the second slow-blink toggle edge
        goto_mode(1);
        goto_mode(2);
        repeat (8) cyc(1'b1, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            cyc(1'b0, 1'b0);
            mode_v[j]  = int'(io.mode);
            led_v[j]   = io.led;
            press_v[j] = io.press_pulse;
        end
        chk("coinc_pulse", int'(press_v[7]), 1);
        chk("coinc_mode_before", mode_v[7], 2);
        chk("coinc_mode_after", mode_v[8], 3);
        chk("coinc_led_edge", int'(led_v[8]), 0);
        for (int j = 9; j <= 11; j++) chk($sformatf("coinc_fast_high%0d", j - 8), int'(led_v[j]), 1);
        chk("coinc_fast_low", int'(led_v[12]), 0);
        repeat (10) cyc(1'b1, 1'b0);

        // Reset in the middle of slow blink
        goto_mode(2);
        repeat (5) cyc(1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 1'b1);
            chk($sformatf("rst%0d_led", j), int'(io.led), 0);
            chk($sformatf("rst%0d_mode", j), int'(io.mode), 0);
            chk($sformatf("rst%0d_press", j), int'(io.press_pulse), 0);
        end
        ones = 0;
        bad_mode = 0;
        repeat (20) begin
            cyc(1'b1, 1'b0);
            ones += int'(io.led);
            if (io.mode != 3'd0) bad_mode++;
        end
        chk("post_rst_led_ones", ones, 0);
        chk("post_rst_mode_moves", bad_mode, 0);

        // Random key activity with occasional resets
        cyc_total = 0;
        while (cyc_total < 3000) begin
            kr  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 99) == 0) begin
                cyc(kr, 1'b1);
                cyc(kr, 1'b1);
                cyc_total += 2;
            end else begin
                for (int c = 0; c < len; c++) cyc(kr, 1'b0);
                cyc_total += len;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
